// File: rtl/i2c_master_byte_if.sv
// Command/response handshake plus open-drain bus pins for the byte-level I2C master.
// The master modport is the I2C master block itself; slave is the host/bus side.
interface i2c_master_byte_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [2:0]            cmd_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  busy_o;
    logic                  scl_o;
    logic                  sda_o;
    logic                  sda_i;

    modport master (
        input  cmd_valid_i, cmd_i, wdata_i, sda_i,
        output cmd_ready_o, rsp_valid_o, rdata_o, ack_o, err_o, busy_o, scl_o, sda_o
    );

    modport slave (
        output cmd_valid_i, cmd_i, wdata_i, sda_i,
        input  cmd_ready_o, rsp_valid_o, rdata_o, ack_o, err_o, busy_o, scl_o, sda_o
    );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START / STOP / WRITE / READ_ACK / READ_NAK commands, one
// response pulse per accepted command. Bus symbols are four quarter-phases of CLK_DIV cycles.
module i2c_master_byte #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    i2c_master_byte_if.master    bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_READ  = 3'd5;

    localparam logic [2:0] CMD_START  = 3'd0;
    localparam logic [2:0] CMD_STOP   = 3'd1;
    localparam logic [2:0] CMD_WRITE  = 3'd2;
    localparam logic [2:0] CMD_RD_ACK = 3'd3;
    localparam logic [2:0] CMD_RD_NAK = 3'd4;

    localparam int             BW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH);
    localparam logic [9:0]     DIV_M1   = 10'(CLK_DIV - 1);

    logic [2:0]            r_state;
    logic [1:0]            r_phase;
    logic [9:0]            r_cnt;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_wsh;
    logic [DATA_WIDTH-1:0] r_rsh;
    logic                  r_nak;
    logic                  r_ack_smp;
    logic                  r_scl;
    logic                  r_sda;
    logic                  r_rsp;
    logic                  r_err;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_busy;

    logic [2:0]            w_state;
    logic [1:0]            w_phase;
    logic [9:0]            w_cnt;
    logic [BW-1:0]         w_bit;
    logic [DATA_WIDTH-1:0] w_wsh;
    logic                  w_nak;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_active;
    logic                  w_sample;
    logic                  w_done;
    logic                  w_reject;
    logic                  w_dbit;
    logic                  w_scl;
    logic                  w_sda;

    // Next-state: command decode on acceptance, otherwise phase/bit sequencing.
    always_comb begin
        w_ready  = (r_state == ST_IDLE) || (r_state == ST_HOLD);
        w_accept = bus.cmd_valid_i && w_ready;
        w_active = !w_ready;
        w_sample = w_active && (r_phase == 2'd1) && (r_cnt == 10'd0);
        w_state  = r_state;
        w_phase  = r_phase;
        w_cnt    = r_cnt;
        w_bit    = r_bit;
        w_wsh    = r_wsh;
        w_nak    = r_nak;
        w_done   = 1'b0;
        w_reject = 1'b0;
        if (w_accept) begin
            case (bus.cmd_i)
                CMD_START: w_state = ST_START;
                CMD_STOP: begin
                    if (r_state == ST_HOLD) w_state = ST_STOP;
                    else                    w_reject = 1'b1;
                end
                CMD_WRITE: begin
                    if (r_state == ST_HOLD) begin
                        w_state = ST_WRITE;
                        w_wsh   = bus.wdata_i;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                CMD_RD_ACK, CMD_RD_NAK: begin
                    if (r_state == ST_HOLD) begin
                        w_state = ST_READ;
                        w_nak   = (bus.cmd_i == CMD_RD_NAK);
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                default: w_reject = 1'b1;
            endcase
            if (!w_reject) begin
                w_cnt   = DIV_M1;
                w_phase = 2'd0;
                w_bit   = '0;
            end
        end else if (w_active) begin
            if (r_cnt != 10'd0) begin
                w_cnt = r_cnt - 10'd1;
            end else begin
                w_cnt   = DIV_M1;
                w_phase = r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    if (((r_state == ST_WRITE) || (r_state == ST_READ)) && (r_bit != LAST_BIT)) begin
                        w_bit = r_bit + BW'(1);
                        w_wsh = {r_wsh[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        w_done  = 1'b1;
                        w_state = (r_state == ST_STOP) ? ST_IDLE : ST_HOLD;
                    end
                end
            end
        end
    end

    // Line levels are derived from the next state so scl/sda come straight from flops.
    always_comb begin
        if (w_state == ST_WRITE)
            w_dbit = (w_bit == LAST_BIT) ? 1'b1 : w_wsh[DATA_WIDTH-1];
        else
            w_dbit = (w_bit == LAST_BIT) ? w_nak : 1'b1;
        w_scl = r_scl;
        w_sda = r_sda;
        case (w_state)
            ST_IDLE: begin
                w_scl = 1'b1;
                w_sda = 1'b1;
            end
            ST_START: begin
                case (w_phase)
                    2'd0:    begin w_scl = r_scl; w_sda = 1'b1; end
                    2'd1:    begin w_scl = 1'b1;  w_sda = 1'b1; end
                    2'd2:    begin w_scl = 1'b1;  w_sda = 1'b0; end
                    default: begin w_scl = 1'b0;  w_sda = 1'b0; end
                endcase
            end
            ST_STOP: begin
                w_scl = (w_phase != 2'd0);
                w_sda = (w_phase[1] == 1'b1);
            end
            ST_WRITE, ST_READ: begin
                w_scl = (w_phase == 2'd1) || (w_phase == 2'd2);
                w_sda = w_dbit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_phase   <= 2'd0;
            r_cnt     <= 10'd0;
            r_bit     <= '0;
            r_wsh     <= '0;
            r_rsh     <= '0;
            r_nak     <= 1'b0;
            r_ack_smp <= 1'b0;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
            r_rsp     <= 1'b0;
            r_err     <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_wsh   <= w_wsh;
            r_nak   <= w_nak;
            r_scl   <= w_scl;
            r_sda   <= w_sda;
            r_rsp   <= w_done || w_reject;
            if (w_sample) begin
                if ((r_state == ST_WRITE) && (r_bit == LAST_BIT))
                    r_ack_smp <= !bus.sda_i;
                if ((r_state == ST_READ) && (r_bit != LAST_BIT))
                    r_rsh <= {r_rsh[DATA_WIDTH-2:0], bus.sda_i};
            end
            if (w_reject)
                r_err <= 1'b1;
            if (w_done) begin
                r_err <= 1'b0;
                if (r_state == ST_WRITE) r_ack   <= r_ack_smp;
                if (r_state == ST_READ)  r_rdata <= r_rsh;
                if (r_state == ST_START) r_busy  <= 1'b1;
                if (r_state == ST_STOP)  r_busy  <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp;
    assign bus.rdata_o     = r_rdata;
    assign bus.ack_o       = r_ack;
    assign bus.err_o       = r_err;
    assign bus.busy_o      = r_busy;
    assign bus.scl_o       = r_scl;
    assign bus.sda_o       = r_sda;
endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a small I2C slave model that ACKs address 0x22.
module tb_i2c_master_byte;
    localparam int CLK_DIV  = 4;
    localparam int DW       = 8;
    localparam int LAT_SYM  = 4 * CLK_DIV + 1;
    localparam int LAT_BYTE = 36 * CLK_DIV + 1;
    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WRITE = 3'd2,
                           C_RACK = 3'd3, C_RNAK = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_byte_if #(.DATA_WIDTH(DW)) bus ();
    i2c_master_byte #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- slave model ----------------
    logic       s_drv;
    logic       w_line;
    int         s_bit = -1;
    int         s_byte = 0;
    logic       s_active = 1'b0, s_done = 1'b0, s_addr_ok = 1'b0, s_rd = 1'b0;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_tx [0:1];
    logic [7:0] s_txb;
    int         s_starts = 0;
    logic [7:0] rx_q [$];
    logic       ack_q [$];
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         busy_low_cnt = 0;
    int         line_low_cnt = 0;

    assign w_line     = bus.sda_o & s_drv;
    assign bus.sda_i  = w_line;

    always_comb begin
        s_drv = 1'b1;
        s_txb = s_tx[(s_byte - 1) & 1];
        if (s_active && !s_done && s_bit >= 0) begin
            if (s_bit == 8) begin
                if ((s_byte == 0 || !s_rd) && s_addr_ok) s_drv = 1'b0;
            end else if (s_byte > 0 && s_rd) begin
                s_drv = s_txb[7 - s_bit];
            end
        end
    end

    always @(negedge clk) begin
        p_scl <= bus.scl_o;
        p_sda <= w_line;
        if (!bus.busy_o) busy_low_cnt <= busy_low_cnt + 1;
        if (!bus.scl_o || !bus.sda_o) line_low_cnt <= line_low_cnt + 1;
        if (bus.scl_o && p_scl && p_sda && !w_line) begin
            s_starts  <= s_starts + 1;
            s_active  <= 1'b1;
            s_done    <= 1'b0;
            s_bit     <= -1;
            s_byte    <= 0;
            s_addr_ok <= 1'b0;
            s_rd      <= 1'b0;
        end else if (bus.scl_o && p_scl && !p_sda && w_line) begin
            s_active <= 1'b0;
            s_bit    <= -1;
        end else if (s_active && bus.scl_o && !p_scl) begin
            if (s_bit >= 0 && s_bit < 8) begin
                s_sh <= {s_sh[6:0], w_line};
                if (s_bit == 7) begin
                    rx_q.push_back({s_sh[6:0], w_line});
                    if (s_byte == 0) begin
                        s_addr_ok <= (s_sh[6:0] == 7'h22);
                        s_rd      <= w_line;
                    end
                end
            end else if (s_bit == 8) begin
                ack_q.push_back(w_line);
                if (w_line) s_done <= 1'b1;
            end
        end else if (s_active && !bus.scl_o && p_scl) begin
            if (s_bit == 8) begin
                s_bit  <= 0;
                s_byte <= s_byte + 1;
            end else begin
                s_bit <= s_bit + 1;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [2:0] c, input logic [7:0] d, output logic ok);
        int n;
        @(negedge clk);
        bus.cmd_i       = c;
        bus.wdata_i     = d;
        bus.cmd_valid_i = 1'b1;
        n = 0;
        while (!bus.cmd_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready_o;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 3'd7;
        bus.wdata_i     = 8'h00;
    endtask

    task automatic wait_rsp(output int lat, output logic bprev);
        lat   = 1;
        bprev = bus.busy_o;
        while (!bus.rsp_valid_o && lat < 2000) begin
            bprev = bus.busy_o;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [7:0] d, output int lat, output logic bprev);
        logic ok;
        send_cmd(c, d, ok);
        wait_rsp(lat, bprev);
        if (!ok) lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 3'd0;
        bus.wdata_i     = 8'h00;
        s_tx[0] = 8'h00;
        s_tx[1] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.scl_o !== 1'b1)       begin n_fail++; $display("FAIL reset_scl got %b exp 1", bus.scl_o); end
        n_tests++; if (bus.sda_o !== 1'b1)       begin n_fail++; $display("FAIL reset_sda got %b exp 1", bus.sda_o); end
        n_tests++; if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready_o); end
        n_tests++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got %b exp 0", bus.rsp_valid_o); end
        n_tests++; if (bus.rdata_o !== 8'h00)    begin n_fail++; $display("FAIL reset_rdata got %h exp 00", bus.rdata_o); end
        n_tests++; if (bus.ack_o !== 1'b0)       begin n_fail++; $display("FAIL reset_ack got %b exp 0", bus.ack_o); end
        n_tests++; if (bus.err_o !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
        n_tests++; if (bus.busy_o !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        int lat, base, abase;
        logic bp, ok;
        base  = rx_q.size();
        abase = ack_q.size();
        run_cmd(C_START, 8'h00, lat, bp);
        n_tests++; if (lat !== LAT_SYM)    begin n_fail++; $display("FAIL wr_start_lat got %0d exp %0d", lat, LAT_SYM); end
        n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL wr_start_busy got %b exp 1", bus.busy_o); end
        send_cmd(C_WRITE, 8'h44, ok);
        n_tests++; if (bus.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL wr_ready_busy got %b exp 0", bus.cmd_ready_o); end
        wait_rsp(lat, bp);
        n_tests++; if (lat !== LAT_BYTE)   begin n_fail++; $display("FAIL wr44_lat got %0d exp %0d", lat, LAT_BYTE); end
        n_tests++; if (bus.ack_o !== 1'b1 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL wr44_ack got ack=%b err=%b exp ack=1 err=0", bus.ack_o, bus.err_o); end
        run_cmd(C_WRITE, 8'hA5, lat, bp);
        n_tests++; if (bus.ack_o !== 1'b1 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL wrA5_ack got ack=%b err=%b exp ack=1 err=0", bus.ack_o, bus.err_o); end
        run_cmd(C_STOP, 8'h00, lat, bp);
        n_tests++; if (lat !== 17 || bp !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL wr_stop_busy got lat=%0d prev=%b busy=%b exp 17 1 0", lat, bp, bus.busy_o); end
        n_tests++; if (bus.scl_o !== 1'b1 || bus.sda_o !== 1'b1) begin n_fail++; $display("FAIL wr_stop_lines got scl=%b sda=%b exp 1 1", bus.scl_o, bus.sda_o); end
        n_tests++; if (rx_q.size() != base + 2 || rx_q[base] !== 8'h44 || rx_q[base+1] !== 8'hA5) begin n_fail++; $display("FAIL wr_sda_bits got n=%0d %h %h exp 44 a5", rx_q.size() - base, rx_q[base], rx_q[base+1]); end
        n_tests++; if (ack_q.size() != abase + 2 || ack_q[abase] !== 1'b0 || ack_q[abase+1] !== 1'b0) begin n_fail++; $display("FAIL wr_ack_slots got n=%0d exp 2 low", ack_q.size() - abase); end
    endtask

    task automatic test_read();
        int lat, base, abase;
        logic bp;
        s_tx[0] = 8'h3C;
        s_tx[1] = 8'hC3;
        base  = rx_q.size();
        abase = ack_q.size();
        run_cmd(C_START, 8'h00, lat, bp);
        run_cmd(C_WRITE, 8'h45, lat, bp);
        n_tests++; if (bus.ack_o !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack got %b exp 1", bus.ack_o); end
        run_cmd(C_RACK, 8'h00, lat, bp);
        n_tests++; if (lat !== LAT_BYTE || bus.rdata_o !== 8'h3C || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rd_ack_data got lat=%0d data=%h err=%b exp %0d 3c 0", lat, bus.rdata_o, bus.err_o, LAT_BYTE); end
        run_cmd(C_RNAK, 8'h00, lat, bp);
        n_tests++; if (bus.rdata_o !== 8'hC3) begin n_fail++; $display("FAIL rd_nak_data got %h exp c3", bus.rdata_o); end
        n_tests++; if (bus.ack_o !== 1'b1) begin n_fail++; $display("FAIL rd_ack_hold got %b exp 1", bus.ack_o); end
        run_cmd(C_STOP, 8'h00, lat, bp);
        n_tests++; if (bus.rdata_o !== 8'hC3) begin n_fail++; $display("FAIL rd_data_hold got %h exp c3", bus.rdata_o); end
        n_tests++; if (rx_q.size() != base + 3 || rx_q[base] !== 8'h45 || rx_q[base+1] !== 8'h3C || rx_q[base+2] !== 8'hC3) begin n_fail++; $display("FAIL rd_bytes got n=%0d exp 45 3c c3", rx_q.size() - base); end
        n_tests++; if (ack_q.size() != abase + 3 || ack_q[abase+1] !== 1'b0 || ack_q[abase+2] !== 1'b1) begin n_fail++; $display("FAIL rd_ninth_bits got n=%0d exp slots x,0,1", ack_q.size() - abase); end
    endtask

    task automatic test_repeated_start();
        int lat, st0, bl0, base;
        logic bp;
        base = rx_q.size();
        st0  = s_starts;
        run_cmd(C_START, 8'h00, lat, bp);
        bl0 = busy_low_cnt;
        run_cmd(C_WRITE, 8'h44, lat, bp);
        run_cmd(C_START, 8'h00, lat, bp);
        n_tests++; if (lat !== LAT_SYM || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rs_start got lat=%0d busy=%b exp %0d 1", lat, bus.busy_o, LAT_SYM); end
        n_tests++; if (s_starts - st0 != 2) begin n_fail++; $display("FAIL rs_sda_fall got %0d starts exp 2", s_starts - st0); end
        run_cmd(C_WRITE, 8'h45, lat, bp);
        n_tests++; if (busy_low_cnt != bl0) begin n_fail++; $display("FAIL rs_busy_drop got %0d low cycles exp 0", busy_low_cnt - bl0); end
        n_tests++; if (rx_q.size() != base + 2 || rx_q[base+1] !== 8'h45) begin n_fail++; $display("FAIL rs_second_addr got n=%0d exp 45", rx_q.size() - base); end
        run_cmd(C_STOP, 8'h00, lat, bp);
    endtask

    task automatic test_reject();
        int lat, ll0;
        logic bp;
        ll0 = line_low_cnt;
        run_cmd(C_WRITE, 8'h55, lat, bp);
        n_tests++; if (lat !== 1 || bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rej_write got lat=%0d err=%b busy=%b exp 1 1 0", lat, bus.err_o, bus.busy_o); end
        run_cmd(3'd6, 8'h00, lat, bp);
        n_tests++; if (lat !== 1 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL rej_code6 got lat=%0d err=%b exp 1 1", lat, bus.err_o); end
        run_cmd(C_STOP, 8'h00, lat, bp);
        n_tests++; if (lat !== 1 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL rej_stop got lat=%0d err=%b exp 1 1", lat, bus.err_o); end
        repeat (4) @(posedge clk);
        n_tests++; if (line_low_cnt != ll0) begin n_fail++; $display("FAIL rej_lines got %0d low cycles exp 0", line_low_cnt - ll0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.cmd_i       = 3'd5;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus.rsp_valid_o !== 1'b1 || bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first got rsp=%b rdy=%b exp 1 1", bus.rsp_valid_o, bus.cmd_ready_o); end
        @(posedge clk); #1;
        n_tests++; if (bus.rsp_valid_o !== 1'b1 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL b2b_second got rsp=%b err=%b exp 1 1", bus.rsp_valid_o, bus.err_o); end
        bus.cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got rsp=%b exp 0", bus.rsp_valid_o); end
    endtask

    task automatic test_noack();
        int lat;
        logic bp;
        run_cmd(C_START, 8'h00, lat, bp);
        n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL na_start_err got %b exp 0", bus.err_o); end
        run_cmd(C_WRITE, 8'hFE, lat, bp);
        n_tests++; if (lat !== LAT_BYTE || bus.ack_o !== 1'b0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL na_write got lat=%0d ack=%b err=%b exp %0d 0 0", lat, bus.ack_o, bus.err_o, LAT_BYTE); end
        run_cmd(C_STOP, 8'h00, lat, bp);
    endtask

    task automatic test_reset_mid();
        int lat, nrsp;
        logic bp, ok;
        run_cmd(C_START, 8'h00, lat, bp);
        send_cmd(C_WRITE, 8'h44, ok);
        repeat (64) @(posedge clk);
        #1;
        n_tests++; if (bus.scl_o !== 1'b0 || bus.sda_o !== 1'b0) begin n_fail++; $display("FAIL rm_bit4 got scl=%b sda=%b exp 0 0", bus.scl_o, bus.sda_o); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.scl_o !== 1'b1 || bus.sda_o !== 1'b1) begin n_fail++; $display("FAIL rm_async_release got scl=%b sda=%b exp 1 1", bus.scl_o, bus.sda_o); end
        nrsp = 0;
        repeat (3) begin @(posedge clk); #1; if (bus.rsp_valid_o) nrsp++; end
        @(negedge clk);
        rst = 1'b0;
        repeat (50) begin @(posedge clk); #1; if (bus.rsp_valid_o) nrsp++; end
        n_tests++; if (nrsp != 0) begin n_fail++; $display("FAIL rm_no_rsp got %0d pulses exp 0", nrsp); end
        n_tests++; if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rm_after got rdy=%b busy=%b exp 1 0", bus.cmd_ready_o, bus.busy_o); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_repeated_start();
        test_reject();
        test_back_to_back();
        test_noack();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
